// File: rtl/ibex_rf_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_write_sched
// Description : Write-port scheduler for the latch-based register file.
//               Runs a zero-initialisation sweep after reset, because the
//               latch array has no reset of its own. After the sweep it
//               arbitrates the single write port between the EX and LSU
//               writebacks. LSU normally wins, but a starvation counter
//               gives EX priority after StarveLimit consecutive denials.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_write_sched #(
   parameter int unsigned DataWidth   = 32,
   parameter bit          RV32E       = 1'b0,
   parameter int unsigned StarveLimit = 3
) (
   input  logic                 clk_int,
   input  logic                 rst_ni,

   input  logic                 ex_req_i,
   input  logic [4:0]           ex_addr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   output logic                 ex_gnt_o,

   input  logic                 lsu_req_i,
   input  logic [4:0]           lsu_addr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 lsu_gnt_o,

   output logic                 init_done_o,

   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int unsigned NUM_WORDS  = RV32E ? 16 : 32;

   // The sweep counter runs one past the last register so that the final
   // sweep write is still issued from INIT; reaching NUM_WORDS marks the end.
   localparam logic [5:0]  INIT_FIRST = 6'd1;
   localparam logic [5:0]  INIT_END   = 6'(NUM_WORDS);

   // RV32E has only 16 registers, so address bit 4 is ignored.
   localparam logic [4:0]  ADDR_MASK  = RV32E ? 5'h0F : 5'h1F;

   localparam logic [3:0]  STARVE_MAX = 4'(StarveLimit);

   localparam logic [0:0]  ST_INIT    = 1'b0;
   localparam logic [0:0]  ST_RUN     = 1'b1;

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [0:0]           state_q, state_d;
   logic [5:0]           init_cnt_q, init_cnt_d;
   logic [3:0]           starve_q, starve_d;

   logic                 we_q, we_d;
   logic [4:0]           waddr_q, waddr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;

   logic [4:0]           ex_addr_eff;
   logic [4:0]           lsu_addr_eff;
   logic                 ex_prio;
   logic                 ex_gnt;
   logic                 lsu_gnt;
   logic                 ex_xfer;
   logic                 lsu_xfer;
   logic                 any_xfer;
   logic [4:0]           sel_addr;
   logic [DataWidth-1:0] sel_wdata;

   // Effective destination addresses after the RV32E bit-4 mask.
   assign ex_addr_eff  = ex_addr_i  & ADDR_MASK;
   assign lsu_addr_eff = lsu_addr_i & ADDR_MASK;

   // EX takes priority only once it has been denied StarveLimit times in a row.
   assign ex_prio = (starve_q == STARVE_MAX);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // State register; reset always returns to the start of the sweep.
   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // Move to RUN once the counter has passed the last register of the sweep.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (init_cnt_q == INIT_END) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output logic (grants)
   // -------------------------------------------------------------------------
   // Grants are combinational and suppressed during the sweep; LSU wins ties
   // unless EX has been starved up to the limit.
   always_comb begin
      ex_gnt  = 1'b0;
      lsu_gnt = 1'b0;
      case (state_q)
         ST_RUN: begin
            lsu_gnt = lsu_req_i & ~(ex_req_i & ex_prio);
            ex_gnt  = ex_req_i & ~lsu_gnt;
         end
         default: begin
            ex_gnt  = 1'b0;
            lsu_gnt = 1'b0;
         end
      endcase
   end

   assign ex_gnt_o    = ex_gnt;
   assign lsu_gnt_o   = lsu_gnt;
   assign init_done_o = (state_q == ST_RUN);

   // -------------------------------------------------------------------------
   // Transfer selection
   // -------------------------------------------------------------------------
   assign ex_xfer   = ex_req_i  & ex_gnt;
   assign lsu_xfer  = lsu_req_i & lsu_gnt;
   assign any_xfer  = ex_xfer | lsu_xfer;
   assign sel_addr  = lsu_xfer ? lsu_addr_eff : ex_addr_eff;
   assign sel_wdata = lsu_xfer ? lsu_wdata_i  : ex_wdata_i;

   // -------------------------------------------------------------------------
   // Sweep counter and starvation counter
   // -------------------------------------------------------------------------
   // Advance the sweep counter in INIT; track consecutive EX denials in RUN.
   always_comb begin
      init_cnt_d = init_cnt_q;
      starve_d   = 4'd0;

      if ((state_q == ST_INIT) && (init_cnt_q != INIT_END)) begin
         init_cnt_d = init_cnt_q + 6'd1;
      end

      if ((state_q == ST_RUN) && ex_req_i && !ex_gnt) begin
         if (starve_q == STARVE_MAX) begin
            starve_d = STARVE_MAX;
         end else begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Write-port next values
   // -------------------------------------------------------------------------
   // Sweep writes zero to the counter address; in RUN a granted transfer is
   // registered unless it targets x0, which is accepted but discarded.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      if (state_q == ST_INIT) begin
         if (init_cnt_q != INIT_END) begin
            we_d    = 1'b1;
            waddr_d = init_cnt_q[4:0];
            wdata_d = '0;
         end
      end else if (any_xfer && (sel_addr != 5'd0)) begin
         we_d    = 1'b1;
         waddr_d = sel_addr;
         wdata_d = sel_wdata;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // Counters and the registered write port; reset drops any pending write.
   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         init_cnt_q <= INIT_FIRST;
         starve_q   <= 4'd0;
         we_q       <= 1'b0;
         waddr_q    <= 5'd0;
         wdata_q    <= '0;
      end else begin
         init_cnt_q <= init_cnt_d;
         starve_q   <= starve_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign rf_we_o    = we_q;
   assign rf_waddr_o = waddr_q;
   assign rf_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rf_write_sched
// Description : Directed testbench for ibex_rf_write_sched. Two instances
//               share the stimulus: a default RV32I build and an RV32E build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_write_sched;

   logic        clk_int = 1'b0;
   logic        rst_ni;
   logic        ex_req;
   logic [4:0]  ex_addr;
   logic [31:0] ex_wdata;
   logic        lsu_req;
   logic [4:0]  lsu_addr;
   logic [31:0] lsu_wdata;

   logic        m_ex_gnt, m_lsu_gnt, m_init_done, m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   logic        e_ex_gnt, e_lsu_gnt, e_init_done, e_we;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_int = ~clk_int;

   ibex_rf_write_sched #(
      .DataWidth   (32),
      .RV32E       (1'b0),
      .StarveLimit (3)
   ) u_dut (
      .clk_int     (clk_int),
      .rst_ni      (rst_ni),
      .ex_req_i    (ex_req),
      .ex_addr_i   (ex_addr),
      .ex_wdata_i  (ex_wdata),
      .ex_gnt_o    (m_ex_gnt),
      .lsu_req_i   (lsu_req),
      .lsu_addr_i  (lsu_addr),
      .lsu_wdata_i (lsu_wdata),
      .lsu_gnt_o   (m_lsu_gnt),
      .init_done_o (m_init_done),
      .rf_we_o     (m_we),
      .rf_waddr_o  (m_waddr),
      .rf_wdata_o  (m_wdata)
   );

   ibex_rf_write_sched #(
      .DataWidth   (32),
      .RV32E       (1'b1),
      .StarveLimit (3)
   ) u_dut_e (
      .clk_int     (clk_int),
      .rst_ni      (rst_ni),
      .ex_req_i    (ex_req),
      .ex_addr_i   (ex_addr),
      .ex_wdata_i  (ex_wdata),
      .ex_gnt_o    (e_ex_gnt),
      .lsu_req_i   (lsu_req),
      .lsu_addr_i  (lsu_addr),
      .lsu_wdata_i (lsu_wdata),
      .lsu_gnt_o   (e_lsu_gnt),
      .init_done_o (e_init_done),
      .rf_we_o     (e_we),
      .rf_waddr_o  (e_waddr),
      .rf_wdata_o  (e_wdata)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Sweep from register 1 up to 'last' with both requests held high; a full
   // sweep (31) ends by checking the first RUN cycle.
   task automatic do_sweep(input int last);
      ex_req    = 1'b1;
      ex_addr   = 5'd7;
      ex_wdata  = 32'h7777_7777;
      lsu_req   = 1'b1;
      lsu_addr  = 5'd8;
      lsu_wdata = 32'h8888_8888;
      for (int k = 1; k <= last; k++) begin
         @(posedge clk_int); #1;
         check_val("sweep we",        {31'd0, m_we},        32'd1);
         check_val("sweep waddr",     {27'd0, m_waddr},     k);
         check_val("sweep wdata",     m_wdata,              32'd0);
         check_val("sweep ex_gnt",    {31'd0, m_ex_gnt},    32'd0);
         check_val("sweep lsu_gnt",   {31'd0, m_lsu_gnt},   32'd0);
         check_val("sweep init_done", {31'd0, m_init_done}, 32'd0);
         if (k <= 15) begin
            check_val("e sweep we",        {31'd0, e_we},        32'd1);
            check_val("e sweep waddr",     {27'd0, e_waddr},     k);
            check_val("e sweep ex_gnt",    {31'd0, e_ex_gnt},    32'd0);
            check_val("e sweep init_done", {31'd0, e_init_done}, 32'd0);
         end else if (k == 16) begin
            check_val("e init_done",  {31'd0, e_init_done}, 32'd1);
            check_val("e we after",   {31'd0, e_we},        32'd0);
         end
      end
      if (last == 31) begin
         ex_req  = 1'b0;
         lsu_req = 1'b0;
         @(posedge clk_int); #1;
         check_val("run init_done", {31'd0, m_init_done}, 32'd1);
         check_val("run we idle",   {31'd0, m_we},        32'd0);
         check_val("run waddr hold",{27'd0, m_waddr},     32'd31);
         check_val("run wdata hold",m_wdata,              32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic exp_ex;

      // Reset with both requests asserted: no grants, all outputs cleared
      rst_ni    = 1'b0;
      ex_req    = 1'b1;
      ex_addr   = 5'd7;
      ex_wdata  = 32'h7777_7777;
      lsu_req   = 1'b1;
      lsu_addr  = 5'd8;
      lsu_wdata = 32'h8888_8888;
      repeat (3) @(posedge clk_int);
      #1;
      check_val("rst we",        {31'd0, m_we},        32'd0);
      check_val("rst waddr",     {27'd0, m_waddr},     32'd0);
      check_val("rst wdata",     m_wdata,              32'd0);
      check_val("rst init_done", {31'd0, m_init_done}, 32'd0);
      check_val("rst ex_gnt",    {31'd0, m_ex_gnt},    32'd0);
      check_val("rst lsu_gnt",   {31'd0, m_lsu_gnt},   32'd0);
      @(negedge clk_int);
      rst_ni = 1'b1;

      do_sweep(31);

      // Single EX write to x5
      ex_addr  = 5'd5;
      ex_wdata = 32'hDEAD_BEEF;
      ex_req   = 1'b1;
      #1;
      check_val("ex gnt",     {31'd0, m_ex_gnt},  32'd1);
      check_val("ex lsu_gnt", {31'd0, m_lsu_gnt}, 32'd0);
      @(posedge clk_int); #1;
      ex_req = 1'b0;
      check_val("ex we",    {31'd0, m_we},    32'd1);
      check_val("ex waddr", {27'd0, m_waddr}, 32'd5);
      check_val("ex wdata", m_wdata,          32'hDEAD_BEEF);
      @(posedge clk_int); #1;
      check_val("ex idle we",    {31'd0, m_we},    32'd0);
      check_val("ex idle waddr", {27'd0, m_waddr}, 32'd5);
      check_val("ex idle wdata", m_wdata,          32'hDEAD_BEEF);

      // Both held: LSU, LSU, LSU, EX, repeating
      ex_addr   = 5'd6;
      ex_wdata  = 32'h1111_1111;
      lsu_addr  = 5'd9;
      lsu_wdata = 32'h2222_2222;
      ex_req    = 1'b1;
      lsu_req   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_ex = ((i % 4) == 3);
         #1;
         check_val("starve ex_gnt",  {31'd0, m_ex_gnt},  {31'd0, exp_ex});
         check_val("starve lsu_gnt", {31'd0, m_lsu_gnt}, {31'd0, ~exp_ex});
         @(posedge clk_int); #1;
         check_val("starve we",    {31'd0, m_we},    32'd1);
         check_val("starve waddr", {27'd0, m_waddr}, exp_ex ? 32'd6 : 32'd9);
         check_val("starve wdata", m_wdata,          exp_ex ? 32'h1111_1111 : 32'h2222_2222);
      end
      ex_req  = 1'b0;
      lsu_req = 1'b0;

      // LSU write to x0: granted, dropped
      lsu_addr  = 5'd0;
      lsu_wdata = 32'h0000_ABCD;
      lsu_req   = 1'b1;
      #1;
      check_val("x0 lsu_gnt", {31'd0, m_lsu_gnt}, 32'd1);
      check_val("x0 ex_gnt",  {31'd0, m_ex_gnt},  32'd0);
      @(posedge clk_int); #1;
      lsu_req = 1'b0;
      check_val("x0 we",    {31'd0, m_we},    32'd0);
      check_val("x0 waddr", {27'd0, m_waddr}, 32'd6);
      check_val("x0 wdata", m_wdata,          32'h1111_1111);

      // Same register from both: LSU first, then EX; EX value persists
      ex_addr   = 5'd12;
      ex_wdata  = 32'hAAAA_0001;
      lsu_addr  = 5'd12;
      lsu_wdata = 32'hBBBB_0002;
      ex_req    = 1'b1;
      lsu_req   = 1'b1;
      #1;
      check_val("coll lsu_gnt", {31'd0, m_lsu_gnt}, 32'd1);
      check_val("coll ex_gnt0", {31'd0, m_ex_gnt},  32'd0);
      @(posedge clk_int); #1;
      lsu_req = 1'b0;
      check_val("coll we1",    {31'd0, m_we},    32'd1);
      check_val("coll waddr1", {27'd0, m_waddr}, 32'd12);
      check_val("coll wdata1", m_wdata,          32'hBBBB_0002);
      #1;
      check_val("coll ex_gnt1", {31'd0, m_ex_gnt}, 32'd1);
      @(posedge clk_int); #1;
      ex_req = 1'b0;
      check_val("coll we2",    {31'd0, m_we},    32'd1);
      check_val("coll waddr2", {27'd0, m_waddr}, 32'd12);
      check_val("coll wdata2", m_wdata,          32'hAAAA_0001);
      @(posedge clk_int); #1;
      check_val("coll idle we", {31'd0, m_we}, 32'd0);

      // Address bit 4 ignored in the RV32E build
      ex_addr  = 5'h13;
      ex_wdata = 32'h1313_1313;
      ex_req   = 1'b1;
      #1;
      check_val("e32 m ex_gnt", {31'd0, m_ex_gnt}, 32'd1);
      check_val("e32 e ex_gnt", {31'd0, e_ex_gnt}, 32'd1);
      @(posedge clk_int); #1;
      ex_req = 1'b0;
      check_val("e32 m waddr", {27'd0, m_waddr}, 32'h13);
      check_val("e32 e we",    {31'd0, e_we},    32'd1);
      check_val("e32 e waddr", {27'd0, e_waddr}, 32'h03);
      check_val("e32 e wdata", e_wdata,          32'h1313_1313);

      lsu_addr  = 5'h10;
      lsu_wdata = 32'h1010_1010;
      lsu_req   = 1'b1;
      #1;
      check_val("e32 e lsu_gnt", {31'd0, e_lsu_gnt}, 32'd1);
      @(posedge clk_int); #1;
      lsu_req = 1'b0;
      check_val("e32 m x16 we",    {31'd0, m_we},    32'd1);
      check_val("e32 m x16 waddr", {27'd0, m_waddr}, 32'h10);
      check_val("e32 e x16 we",    {31'd0, e_we},    32'd0);
      check_val("e32 e x16 waddr", {27'd0, e_waddr}, 32'h03);

      // Reset mid-RUN with a pending write visible
      ex_addr  = 5'd3;
      ex_wdata = 32'h3333_3333;
      ex_req   = 1'b1;
      @(posedge clk_int); #1;
      ex_req = 1'b0;
      check_val("pend we", {31'd0, m_we}, 32'd1);
      rst_ni = 1'b0;
      #1;
      check_val("mrun rst we",        {31'd0, m_we},        32'd0);
      check_val("mrun rst waddr",     {27'd0, m_waddr},     32'd0);
      check_val("mrun rst init_done", {31'd0, m_init_done}, 32'd0);
      repeat (2) @(posedge clk_int);
      @(negedge clk_int);
      rst_ni = 1'b1;

      // Reset mid-sweep at address 10, then a full restarted sweep
      do_sweep(10);
      rst_ni = 1'b0;
      #1;
      check_val("minit rst we",      {31'd0, m_we},      32'd0);
      check_val("minit rst ex_gnt",  {31'd0, m_ex_gnt},  32'd0);
      check_val("minit rst lsu_gnt", {31'd0, m_lsu_gnt}, 32'd0);
      repeat (2) @(posedge clk_int);
      @(negedge clk_int);
      rst_ni = 1'b1;
      do_sweep(31);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
